// File: rtl/count_cap_pkg.sv
// Shared types and constants for the count capture unit.
// Counter width, wrap value, timestamp word layout and pointer sizing.
package count_cap_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
    localparam int EXT_W_DEF = 4;

    typedef struct packed {
        logic [EXT_W_DEF-1:0] ext;
        logic [CNT_W-1:0]     cnt;
    } cap_word_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cap_fifo.sv
// First-word-fall-through FIFO for timestamp words.
// Pointers carry an extra MSB to tell full from empty.
module cap_fifo
    import count_cap_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = ptr_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          wr_en, rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees a slot, so a push into a full FIFO is fine alongside it
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // Pointer advance and last-popped word kept for the empty output
    always_comb begin
        wr_d   = wr_q + {{AW{1'b0}}, wr_en};
        rd_d   = rd_q + {{AW{1'b0}}, rd_en};
        hold_d = rd_en ? mem_q[rd_q[AW-1:0]] : hold_q;
    end

    // Pointer and hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            hold_q <= hold_d;
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? hold_q : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/count_capture_unit.sv
// Extends the 4-bit counter with a wrap count and timestamps captures.
// COUNT_CAP_SYNC_EN: synchronise capture_req and capture on its rising edge.
module count_capture_unit
    import count_cap_pkg::*;
#(
    parameter int EXT_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       count_in,
    input  logic                   capture_req,
    input  logic                   out_ready,
    input  logic                   ovr_clr,
    output logic                   out_valid,
    output logic [EXT_W+CNT_W-1:0] out_data,
    output logic                   wrap_pulse,
    output logic [EXT_W-1:0]       ext_cnt,
    output logic                   overrun
);

    localparam int W = EXT_W + CNT_W;

    logic [CNT_W-1:0] prev_q;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic             wrap_q;
    logic             ovr_q, ovr_d;
    logic             wrap, cap_ev, pop, drop;
    logic             full, empty;
    logic [W-1:0]     word;

`ifdef COUNT_CAP_SYNC_EN
    logic [2:0] sync_q;

    // Two-flop synchroniser plus one flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], capture_req};
    end

    assign cap_ev = sync_q[1] & ~sync_q[2];
`else
    assign cap_ev = capture_req;
`endif

    // Only F->0 is a wrap; other drops are counter resets
    assign wrap  = (prev_q == CNT_MAX) && (count_in == '0);
    assign ext_d = wrap ? ext_q + {{(EXT_W-1){1'b0}}, 1'b1} : ext_q;
    assign word  = {ext_d, count_in};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = cap_ev && full && !pop;
    assign ovr_d     = drop ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

    // Counter history, extension, wrap pulse and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            ext_q  <= '0;
            wrap_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            prev_q <= count_in;
            ext_q  <= ext_d;
            wrap_q <= wrap;
            ovr_q  <= ovr_d;
        end
    end

    cap_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cap_ev),
        .pop_i   (pop),
        .data_i  (word),
        .data_o  (out_data),
        .full_o  (full),
        .empty_o (empty)
    );

    assign wrap_pulse = wrap_q;
    assign ext_cnt    = ext_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/count_capture_unit.md
# count_capture_unit

Downstream consumer of the 4-bit free-running counter's `count` output. It extends the counter with a wrap-extension register and timestamps external capture events as `{ext, count}` words. It buffers those words in a small FIFO and drains them over a valid/ready handshake. It gives the rest of the design wide timestamps without widening the counter itself.

## Interface
Parameters:
- `EXT_W`, 4: width of the wrap-extension count.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `count_in`, in, 4: counter value, sampled every cycle.
- `capture_req`, in, 1: capture event.
- `out_ready`, in, 1: consumer ready.
- `ovr_clr`, in, 1: clears the sticky overrun flag.
- `out_valid`, out, 1: FIFO head valid.
- `out_data`, out, EXT_W+4: timestamp at FIFO head, `{ext, count}`.
- `wrap_pulse`, out, 1: one-cycle pulse on a counter wrap.
- `ext_cnt`, out, EXT_W: current extension value.
- `overrun`, out, 1: sticky flag; a capture was dropped.

## Operation
- **Previous value:** `prev` is a register holding last cycle's `count_in`.
- **Wrap detection:** a wrap occurs when `prev==4'hF && count_in==4'h0`.
- **Wrap handling:** on a wrap, `ext_cnt` increments modulo 2^EXT_W and `wrap_pulse` is registered high for the following cycle.
- **Non-wrap drops:** any other decrease of `count_in` (counter reset) is not a wrap. `ext_cnt` is unchanged.
- **Capture word:** on a capture event, the word is `{ext_next, count_in}`.
  - `ext_next` is the post-increment extension if a wrap occurs in the same cycle.
  - A capture coincident with a wrap therefore yields `{ext+1, 0}`, never `{ext, 0}`.
- **FIFO:** first-word-fall-through.
  - Push happens on a capture event.
  - Pop happens when `out_valid && out_ready`.
  - `out_data` is held stable while `out_valid && !out_ready`.
- **Full FIFO:**
  - Push with no pop: the word is dropped and `overrun` is set.
  - Push and pop in the same cycle: both succeed and occupancy is unchanged.
- **Empty FIFO:** pop is ignored. `out_valid=0`. `out_data` holds its last value.
- **Overrun clear:** `ovr_clr` clears `overrun`. If a drop occurs in the same cycle, set wins.
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `wrap_pulse=0`, `ext_cnt=0`, `overrun=0`.
  - FIFO empty, `prev=0`, synchronizer flops 0.
- **Reset mid-operation:** all buffered words are discarded.

## Timing
- **Capture to output:** a capture event in cycle N produces `out_valid` in cycle N+1 (FIFO empty case).
- **Wrap to pulse:** a wrap in cycle N produces `wrap_pulse` in cycle N+1. `ext_cnt` shows the new value in N+1.
- **Throughput:** one capture per cycle is accepted while the FIFO is not full. One word per cycle drains.
- **Synchronized mode:** with `COUNT_CAP_SYNC_EN`, the capture event is recognised 2 cycles after the `capture_req` rising edge is sampled. `out_valid` follows one cycle later (N+3).

## Configuration
Macro: `COUNT_CAP_SYNC_EN`.
- **Defined:**
  - `capture_req` passes through a 2-flop synchronizer, followed by rising-edge detection against a third flop.
  - A held-high request yields exactly one capture.
  - The timestamp is taken in the edge-detect cycle.
- **Undefined:**
  - `capture_req` is a synchronous per-cycle strobe.
  - Each high cycle is one capture event, so a held-high request captures every cycle.

## Structure
- **Shared package:** `count_cap_pkg`, containing:
  - `CNT_W=4` and `CNT_MAX=4'hF`;
  - the typedef `cap_word_t` as a packed struct `{ext, cnt}`;
  - a width helper function for the FIFO pointers.
- **Sub-module:** `cap_fifo`, a parameterised synchronous FWFT FIFO with `full`/`empty` and an extra pointer MSB for full/empty disambiguation.
- **Top level:** wrap detection, extension counter, capture logic and overrun handling stay in the top.

## Test plan
- **Free run:**
  - Stimulus: `rst` for 2 cycles, then `count_in` increments 0..F,0..F,0.
  - Required: `wrap_pulse` high exactly 2 times; `ext_cnt` reaches 2.
- **Wrap coincident capture:**
  - Stimulus: capture in the cycle `count_in` goes F→0 with `ext_cnt=3`.
  - Required: `out_data=8'h40` (EXT_W=4).
- **Fill and overflow:**
  - Stimulus: `out_ready=0`, 5 captures at counts 1,2,3,4,5.
  - Required: 4 words held, `overrun=1`, and drain order is 1,2,3,4.
  - Then: `ovr_clr` clears `overrun`.
- **Full with simultaneous push/pop:**
  - Stimulus: FIFO full, `out_ready=1`, capture at count 7.
  - Required: `overrun` stays 0 and the last drained word is `{ext,7}`.
- **Counter reset is not a wrap:**
  - Stimulus: `count_in` drops 9→0.
  - Required: no `wrap_pulse`, `ext_cnt` unchanged.
- **Synchronized mode (`COUNT_CAP_SYNC_EN`):**
  - Stimulus: `capture_req` held high for 6 cycles.
  - Required: exactly one word, with `out_valid` 3 cycles after the edge. Then apply `rst` mid-stream: FIFO empties and `out_valid=0` the next cycle.
